// File: rtl/keypad_scan_ctrl_if.sv
// Key hand-off bus between the keypad scanner and its consumer.
//   key_code    : accepted key, row*NUM_COLS + col
//   is_sign_key : accepted key sits in the sign column
//   key_valid   : key_code/is_sign_key are valid, held until taken
//   key_ready   : consumer takes the key when high together with key_valid
// The master modport is the scanner side, the slave modport the consumer side.
interface keypad_scan_ctrl_if #(
  parameter int CODE_W = 4
) ();
  logic [CODE_W-1:0] key_code;
  logic              is_sign_key;
  logic              key_valid;
  logic              key_ready;

  modport master (
    output key_code,
    output is_sign_key,
    output key_valid,
    input  key_ready
  );

  modport slave (
    input  key_code,
    input  is_sign_key,
    input  key_valid,
    output key_ready
  );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: drives one column at a time, samples the synchronized
// rows at the end of each dwell, debounces a single pressed key, hands it to the
// consumer once per press and waits for a debounced release before scanning on.
// Ports:
//   slow_clk    : scan clock, all state on the rising edge
//   rst         : asynchronous active-low reset
//   row_in      : raw row sense, bit r = row r, 1 = contact
//   col_drive   : one-hot column drive, bit c = column c
//   key_pressed : a debounced key is held (reported or awaiting release)
//   ghost_err   : one-cycle pulse when a sampled column shows several rows
//   key_if      : key hand-off bus (master side)
module keypad_scan_ctrl #(
  parameter int NUM_ROWS        = 4,
  parameter int NUM_COLS        = 4,
  parameter int SETTLE_CYCLES   = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SIGN_COL        = NUM_COLS - 1
) (
  input  logic                slow_clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] row_in,
  output logic [NUM_COLS-1:0] col_drive,
  output logic                key_pressed,
  output logic                ghost_err,
  keypad_scan_ctrl_if.master  key_if
);

  localparam int CODE_W  = ($clog2(NUM_ROWS * NUM_COLS) < 1) ? 1 : $clog2(NUM_ROWS * NUM_COLS);
  localparam int ROW_W   = ($clog2(NUM_ROWS) < 1) ? 1 : $clog2(NUM_ROWS);
  localparam int COL_W   = ($clog2(NUM_COLS) < 1) ? 1 : $clog2(NUM_COLS);
  localparam int DWELL_W = $clog2(SETTLE_CYCLES);
  localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_SCAN         = 2'd0,
    ST_DEBOUNCE     = 2'd1,
    ST_VALID        = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } state_t;

  // Index of the (single) set bit of a row pattern.
  function automatic logic [ROW_W-1:0] row_index(input logic [NUM_ROWS-1:0] pat);
    logic [ROW_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (pat[i]) idx = ROW_W'(i);
    end
    return idx;
  endfunction

  // True when more than one row bit is set (clearing the lowest set bit leaves something).
  function automatic logic multi_bit(input logic [NUM_ROWS-1:0] pat);
    return (pat & (pat - NUM_ROWS'(1))) != '0;
  endfunction

  function automatic logic [COL_W-1:0] next_col(input logic [COL_W-1:0] col);
    logic [COL_W-1:0] nxt;
    if (col == COL_W'(NUM_COLS - 1)) nxt = '0;
    else                             nxt = col + COL_W'(1);
    return nxt;
  endfunction

  function automatic logic [NUM_COLS-1:0] col_onehot(input logic [COL_W-1:0] col);
    return NUM_COLS'(1) << col;
  endfunction

  state_t              state_r, state_nxt_s;
  logic [NUM_ROWS-1:0] sync1_r, rows_r;
  logic [COL_W-1:0]    col_idx_r, col_idx_nxt_s;
  logic [DWELL_W-1:0]  dwell_r, dwell_nxt_s;
  logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
  logic [NUM_ROWS-1:0] pat_r, pat_nxt_s;
  logic [ROW_W-1:0]    row_idx_r, row_idx_nxt_s;
  logic [NUM_COLS-1:0] col_drive_r;
  logic [CODE_W-1:0]   key_code_r, key_code_s;
  logic                is_sign_r, key_valid_r, key_pressed_r, ghost_r;
  logic                ghost_nxt_s, load_key_s;

  // Next-state logic for the scan / debounce / hand-off / release sequence.
  always_comb begin
    state_nxt_s   = state_r;
    col_idx_nxt_s = col_idx_r;
    dwell_nxt_s   = dwell_r;
    cnt_nxt_s     = cnt_r;
    pat_nxt_s     = pat_r;
    row_idx_nxt_s = row_idx_r;
    ghost_nxt_s   = 1'b0;
    load_key_s    = 1'b0;
    key_code_s    = CODE_W'(row_idx_r) * CODE_W'(NUM_COLS) + CODE_W'(col_idx_r);
    case (state_r)
      ST_SCAN: begin
        if (dwell_r == DWELL_W'(SETTLE_CYCLES - 1)) begin
          // Rows only reflect this column after the two-flop synchronizer,
          // so the sample is taken on the last cycle of the dwell.
          dwell_nxt_s = '0;
          if (rows_r == '0) begin
            col_idx_nxt_s = next_col(col_idx_r);
          end else if (multi_bit(rows_r)) begin
            ghost_nxt_s   = 1'b1;
            col_idx_nxt_s = next_col(col_idx_r);
          end else begin
            pat_nxt_s     = rows_r;
            row_idx_nxt_s = row_index(rows_r);
            cnt_nxt_s     = '0;
            state_nxt_s   = ST_DEBOUNCE;
          end
        end else begin
          dwell_nxt_s = dwell_r + DWELL_W'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (rows_r == pat_r) begin
          if (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt_nxt_s   = '0;
            load_key_s  = 1'b1;
            state_nxt_s = ST_VALID;
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          cnt_nxt_s     = '0;
          dwell_nxt_s   = '0;
          col_idx_nxt_s = next_col(col_idx_r);
          state_nxt_s   = ST_SCAN;
        end
      end
      ST_VALID: begin
        // Key release is ignored here: the key stays offered until taken.
        if (key_valid_r && key_if.key_ready) begin
          cnt_nxt_s   = '0;
          state_nxt_s = ST_WAIT_RELEASE;
        end else begin
          state_nxt_s = ST_VALID;
        end
      end
      ST_WAIT_RELEASE: begin
        if (rows_r == '0) begin
          if (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt_nxt_s     = '0;
            dwell_nxt_s   = '0;
            col_idx_nxt_s = next_col(col_idx_r);
            state_nxt_s   = ST_SCAN;
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          cnt_nxt_s = '0;
        end
      end
      default: begin
        state_nxt_s   = ST_SCAN;
        col_idx_nxt_s = '0;
        dwell_nxt_s   = '0;
        cnt_nxt_s     = '0;
      end
    endcase
  end

  // State, synchronizer and registered outputs.
  always_ff @(posedge slow_clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_SCAN;
      sync1_r       <= '0;
      rows_r        <= '0;
      col_idx_r     <= '0;
      dwell_r       <= '0;
      cnt_r         <= '0;
      pat_r         <= '0;
      row_idx_r     <= '0;
      col_drive_r   <= NUM_COLS'(1);
      key_code_r    <= '0;
      is_sign_r     <= 1'b0;
      key_valid_r   <= 1'b0;
      key_pressed_r <= 1'b0;
      ghost_r       <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      sync1_r       <= row_in;
      rows_r        <= sync1_r;
      col_idx_r     <= col_idx_nxt_s;
      dwell_r       <= dwell_nxt_s;
      cnt_r         <= cnt_nxt_s;
      pat_r         <= pat_nxt_s;
      row_idx_r     <= row_idx_nxt_s;
      col_drive_r   <= col_onehot(col_idx_nxt_s);
      ghost_r       <= ghost_nxt_s;
      key_valid_r   <= (state_nxt_s == ST_VALID);
      key_pressed_r <= (state_nxt_s == ST_VALID) || (state_nxt_s == ST_WAIT_RELEASE);
      if (load_key_s) begin
        key_code_r <= key_code_s;
        is_sign_r  <= (col_idx_r == COL_W'(SIGN_COL));
      end
    end
  end

  assign col_drive          = col_drive_r;
  assign key_pressed        = key_pressed_r;
  assign ghost_err          = ghost_r;
  assign key_if.key_code    = key_code_r;
  assign key_if.is_sign_key = is_sign_r;
  assign key_if.key_valid   = key_valid_r;

endmodule
